// File: rtl/ctr_priority_sched_if.sv
// Bus between the memory-cycle timer control and the counter-cell priority scheduler.
// The master side drives the strobes and request levels; the slave side returns the grant.
interface ctr_priority_sched_if #(
    parameter int NREQ = 20,
    parameter int IW   = 5
);
    logic            GOJAM;
    logic            STOP;
    logic            T12;
    logic            INKL;
    logic [NREQ-1:0] REQ;
    logic            CTROR;
    logic [NREQ-1:0] GNT;
    logic [IW-1:0]   GNT_IDX;
    logic [NREQ-1:0] PEND;
    logic            OVR;

    modport master (
        output GOJAM, STOP, T12, INKL, REQ,
        input  CTROR, GNT, GNT_IDX, PEND, OVR
    );

    modport slave (
        input  GOJAM, STOP, T12, INKL, REQ,
        output CTROR, GNT, GNT_IDX, PEND, OVR
    );
endinterface

// File: rtl/ctr_priority_sched.sv
// Counter-cell priority scheduler: latches request edges, steals the next MCT for the lowest pending index.
// Optional macro CTR_BURST_LIMIT_EN caps consecutive counter MCTs at BURST_MAX.

// One request cell: edge detector plus pending bit.
module ctr_priority_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic gojam_i,
    input  logic req_i,
    input  logic clr_i,
    output logic pend_o,
    output logic ovr_hit_o
);
    logic req_q;
    logic pend_q, pend_d;
    logic edge_w;

    assign edge_w    = req_i & ~req_q;
    // A grant clearing this bit absorbs the old request, so a coincident edge is not an overrun.
    assign ovr_hit_o = edge_w & pend_q & ~clr_i;
    assign pend_d    = gojam_i ? 1'b0 : ((pend_q & ~clr_i) | edge_w);
    assign pend_o    = pend_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            req_q  <= req_i;
            pend_q <= pend_d;
        end
    end
endmodule

module ctr_priority_sched #(
    parameter int NREQ      = 20,
    parameter int IW        = 5,
    parameter int BURST_MAX = 4
) (
    input  logic                 SIM_CLK,
    input  logic                 SIM_RST,
    ctr_priority_sched_if.slave  bus
);
    if ((2 ** IW) < NREQ || BURST_MAX < 1) begin : g_param_chk
        $error("ctr_priority_sched: IW too narrow for NREQ or BURST_MAX < 1");
    end

    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] ovr_hit;
    logic [NREQ-1:0] pick_oh;
    logic [NREQ-1:0] clr;
    logic [IW-1:0]   pick_idx;
    logic            qual;
    logic            grant;
    logic            burst_hold;

    logic            ctror_q, ctror_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
    logic            ovr_q, ovr_d;

    // Lowest set bit isolates the highest-priority pending cell.
    assign pick_oh = pend & (~pend + NREQ'(1));

    always_comb begin
        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pend[i]) pick_idx = IW'(i);
        end
    end

    assign qual  = bus.T12 & ~bus.STOP;
    assign grant = qual & ~bus.INKL & (|pend) & ~burst_hold;
    assign clr   = grant ? pick_oh : '0;

    for (genvar g = 0; g < NREQ; g++) begin : g_cell
        ctr_priority_cell u_cell (
            .clk_i     (SIM_CLK),
            .rst_ni    (SIM_RST),
            .gojam_i   (bus.GOJAM),
            .req_i     (bus.REQ[g]),
            .clr_i     (clr[g]),
            .pend_o    (pend[g]),
            .ovr_hit_o (ovr_hit[g])
        );
    end

`ifdef CTR_BURST_LIMIT_EN
    localparam int BW = $clog2(BURST_MAX + 1);
    logic [BW-1:0] burst_q, burst_d;

    assign burst_hold = qual & (burst_q == BW'(BURST_MAX));

    // Grants only happen below BURST_MAX, so the increment never wraps.
    always_comb begin
        burst_d = burst_q;
        if (bus.GOJAM)  burst_d = '0;
        else if (qual)  burst_d = grant ? burst_q + BW'(1) : '0;
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) burst_q <= '0;
        else          burst_q <= burst_d;
    end
`else
    assign burst_hold = 1'b0;
`endif

    always_comb begin
        ctror_d   = ctror_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ovr_d     = ovr_q | (|ovr_hit);
        if (bus.GOJAM) begin
            ctror_d   = 1'b0;
            gnt_d     = '0;
            gnt_idx_d = '0;
            ovr_d     = 1'b0;
        end else if (qual) begin
            ctror_d   = grant;
            gnt_d     = clr;
            gnt_idx_d = grant ? pick_idx : '0;
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            ctror_q   <= 1'b0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            ctror_q   <= ctror_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.CTROR   = ctror_q;
    assign bus.GNT     = gnt_q;
    assign bus.GNT_IDX = gnt_idx_q;
    assign bus.PEND    = pend;
    assign bus.OVR     = ovr_q;
endmodule

// File: tb/tb_ctr_priority_sched.sv
// Directed table-driven bench for ctr_priority_sched plus hand sequences for reset and burst behaviour.
module tb_ctr_priority_sched;
    localparam int NREQ = 20;
    localparam int IW   = 5;

    logic SIM_CLK = 1'b0;
    logic SIM_RST = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    always #5 SIM_CLK = ~SIM_CLK;

    ctr_priority_sched_if #(.NREQ(NREQ), .IW(IW)) bus ();

    ctr_priority_sched #(.NREQ(NREQ), .IW(IW), .BURST_MAX(4)) dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [NREQ-1:0] req;
        logic            t12;
        logic            inkl;
        logic            stop;
        logic            gojam;
        logic            ctror;
        logic [IW-1:0]   idx;
        logic [NREQ-1:0] pend;
        logic            ovr;
    } vec_t;

    vec_t vecs [31];

    function automatic vec_t mk(input logic [NREQ-1:0] req, input logic t12, input logic inkl,
                                input logic stop, input logic gojam, input logic ctror,
                                input int idx, input logic [NREQ-1:0] pend, input logic ovr);
        vec_t v;
        v.req = req; v.t12 = t12; v.inkl = inkl; v.stop = stop; v.gojam = gojam;
        v.ctror = ctror; v.idx = IW'(idx); v.pend = pend; v.ovr = ovr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [NREQ-1:0] req, input logic t12, input logic inkl,
                        input logic stop, input logic gojam);
        @(negedge SIM_CLK);
        bus.REQ = req; bus.T12 = t12; bus.INKL = inkl; bus.STOP = stop; bus.GOJAM = gojam;
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic ctror, input logic [IW-1:0] idx,
                           input logic [NREQ-1:0] pend, input logic ovr);
        logic [NREQ-1:0] gexp;
        gexp = '0;
        if (ctror) gexp[idx] = 1'b1;
        chk({nm, ".CTROR"},   32'(bus.CTROR),   32'(ctror));
        chk({nm, ".GNT_IDX"}, 32'(bus.GNT_IDX), 32'(idx));
        chk({nm, ".GNT"},     32'(bus.GNT),     32'(gexp));
        chk({nm, ".PEND"},    32'(bus.PEND),    32'(pend));
        chk({nm, ".OVR"},     32'(bus.OVR),     32'(ovr));
    endtask

    localparam logic [NREQ-1:0] B0  = 20'h1;
    localparam logic [NREQ-1:0] B1  = 20'h2;
    localparam logic [NREQ-1:0] B2  = 20'h4;
    localparam logic [NREQ-1:0] B3  = 20'h8;
    localparam logic [NREQ-1:0] B4  = 20'h10;
    localparam logic [NREQ-1:0] B5  = 20'h20;
    localparam logic [NREQ-1:0] B6  = 20'h40;
    localparam logic [NREQ-1:0] B7  = 20'h80;
    localparam logic [NREQ-1:0] B9  = 20'h200;
    localparam logic [NREQ-1:0] B11 = 20'h800;
    localparam logic [NREQ-1:0] Z   = 20'h0;

    initial begin
        logic exp_c [6];
        logic [NREQ-1:0] exp_pend_end;

        //            req      t12 ink stp gj  ctr idx pend     ovr
        vecs[0]  = mk(Z,       0,  0,  0,  0,  0,  0,  Z,       0);
        vecs[1]  = mk(B5|B2,   0,  0,  0,  0,  0,  0,  B5|B2,   0);
        vecs[2]  = mk(Z,       1,  0,  0,  0,  1,  2,  B5,      0);
        vecs[3]  = mk(Z,       0,  0,  0,  0,  1,  2,  B5,      0);
        vecs[4]  = mk(Z,       1,  0,  0,  0,  1,  5,  Z,       0);
        vecs[5]  = mk(Z,       1,  0,  0,  0,  0,  0,  Z,       0);
        vecs[6]  = mk(B3,      0,  0,  0,  0,  0,  0,  B3,      0);
        vecs[7]  = mk(Z,       0,  0,  0,  0,  0,  0,  B3,      0);
        vecs[8]  = mk(B3,      0,  0,  0,  0,  0,  0,  B3,      1);
        vecs[9]  = mk(Z,       1,  0,  0,  0,  1,  3,  Z,       1);
        vecs[10] = mk(Z,       1,  0,  0,  0,  0,  0,  Z,       1);
        vecs[11] = mk(Z,       0,  0,  0,  1,  0,  0,  Z,       0);
        vecs[12] = mk(B0,      0,  0,  0,  0,  0,  0,  B0,      0);
        vecs[13] = mk(Z,       1,  1,  0,  0,  0,  0,  B0,      0);
        vecs[14] = mk(Z,       1,  0,  0,  0,  1,  0,  Z,       0);
        vecs[15] = mk(B6,      0,  0,  0,  0,  1,  0,  B6,      0);
        vecs[16] = mk(Z,       0,  0,  0,  0,  1,  0,  B6,      0);
        vecs[17] = mk(B6,      1,  0,  0,  0,  1,  6,  B6,      0);
        vecs[18] = mk(Z,       1,  0,  0,  0,  1,  6,  Z,       0);
        vecs[19] = mk(B7,      0,  0,  0,  0,  1,  6,  B7,      0);
        vecs[20] = mk(Z,       1,  0,  0,  0,  1,  7,  Z,       0);
        vecs[21] = mk(B1,      1,  0,  1,  0,  1,  7,  B1,      0);
        vecs[22] = mk(Z,       1,  0,  1,  0,  1,  7,  B1,      0);
        vecs[23] = mk(Z,       1,  0,  1,  0,  1,  7,  B1,      0);
        vecs[24] = mk(Z,       1,  0,  0,  0,  1,  1,  Z,       0);
        vecs[25] = mk(B9,      1,  0,  0,  0,  0,  0,  B9,      0);
        vecs[26] = mk(Z,       1,  0,  0,  0,  1,  9,  Z,       0);
        vecs[27] = mk(B4,      0,  0,  0,  0,  1,  9,  B4,      0);
        vecs[28] = mk(B4,      0,  0,  0,  1,  0,  0,  Z,       0);
        vecs[29] = mk(B4,      1,  0,  0,  0,  0,  0,  Z,       0);
        vecs[30] = mk(B4,      0,  0,  0,  0,  0,  0,  Z,       0);

        bus.REQ = '0; bus.T12 = 1'b0; bus.INKL = 1'b0; bus.STOP = 1'b0; bus.GOJAM = 1'b0;
        #12;
        chk_all("reset", 1'b0, '0, '0, 1'b0);
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;

        foreach (vecs[k]) begin
            step(vecs[k].req, vecs[k].t12, vecs[k].inkl, vecs[k].stop, vecs[k].gojam);
            chk_all($sformatf("vec%0d", k), vecs[k].ctror, vecs[k].idx, vecs[k].pend, vecs[k].ovr);
        end

        // Async reset in the middle of a counter MCT, with REQ[4] still held high.
        step(B4 | B11, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("pre_rst_pend", 1'b0, '0, B11, 1'b0);
        step(B4 | B11, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("pre_rst_gnt", 1'b1, 5'd11, Z, 1'b0);
        #2;
        SIM_RST = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, '0, Z, 1'b0);
        @(negedge SIM_CLK);
        bus.REQ = B4;
        SIM_RST = 1'b1;
        @(posedge SIM_CLK);
        #1;
        chk_all("rst_release_edge", 1'b0, '0, B4, 1'b0);

        // Six pending requests, six back-to-back qualifying T12 strobes.
        step(B4 | B0 | B1 | B2 | B3 | B5, 1'b0, 1'b0, 1'b0, 1'b1);
        step(Z, 1'b0, 1'b0, 1'b0, 1'b0);
        step(B0 | B1 | B2 | B3 | B4 | B5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("burst_load", 1'b0, '0, 20'h3F, 1'b0);
`ifdef CTR_BURST_LIMIT_EN
        exp_c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_pend_end = B5;
`else
        exp_c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_pend_end = Z;
`endif
        for (int k = 0; k < 6; k++) begin
            step(Z, 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("burst%0d.CTROR", k), 32'(bus.CTROR), 32'(exp_c[k]));
        end
        chk("burst_end.PEND", 32'(bus.PEND), 32'(exp_pend_end));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ctr_priority_sched.md
Name: ctr_priority_sched

Overview:
- Counter-cell priority scheduler for the memory-cycle timer.
- Latches asynchronous-origin counter-increment requests (PINC/MINC/shift/etc. cells) as edge-detected pending bits.
- At each end-of-MCT strobe (T12), steals the next memory cycle for the highest-priority pending cell.
- Drives the counter-cycle flag and a one-hot grant that the control-pulse logic uses for the whole following MCT.

Parameters:
- NREQ, 20, number of counter-cell request lines; index 0 = highest priority.
- IW, 5, width of GNT_IDX; must satisfy 2**IW >= NREQ.
- BURST_MAX, 4, maximum consecutive counter MCTs (used only with CTR_BURST_LIMIT_EN).

Ports:
- SIM_CLK  in  1  system clock; all state updates on rising edge.
- SIM_RST  in  1  asynchronous, active-low reset.
- GOJAM  in  1  synchronous restart; clears scheduler state.
- STOP  in  1  monitor stop; freezes grant sequencing.
- T12  in  1  one-SIM_CLK-wide strobe marking end of an MCT.
- INKL  in  1  inhibit counter cycles; no new grant while high.
- REQ  in  NREQ  request levels; rising edge = one increment request.
- CTROR  out  1  current MCT is a counter cycle.
- GNT  out  NREQ  one-hot granted cell; all zero when CTROR=0.
- GNT_IDX  out  IW  index of granted cell; 0 when CTROR=0.
- PEND  out  NREQ  pending-request bit vector.
- OVR  out  1  sticky overrun: request lost.

Behaviour:
- Reset (SIM_RST=0, async): PEND=0, GNT=0, GNT_IDX=0, CTROR=0, OVR=0, req_q=0, burst count=0.
- Edge detect: req_q <= REQ every cycle, including during GOJAM and STOP. edge = REQ & ~req_q.
  - A REQ bit high at reset release yields an edge in the first clocked cycle.
- Pending: PEND[i] set on edge[i]; cleared only when granted or by GOJAM.
- Overrun: edge[i] while PEND[i]=1, and bit i not cleared by a grant this cycle → OVR<=1 (sticky). PEND[i] stays 1; the request is counted once.
- Grant decision, only on cycles with T12=1 and STOP=0:
  - If INKL=0 and PEND≠0: i = lowest set index. Next cycle GNT=onehot(i), GNT_IDX=i, CTROR=1. PEND[i] cleared the same edge.
  - Otherwise: GNT=0, GNT_IDX=0, CTROR=0.
  - Decision uses PEND as registered before this edge; edges arriving in the T12 cycle are not eligible until the next T12.
- Grant latency: 1 SIM_CLK after T12. Outputs are held constant until the next qualifying T12.
- Simultaneous grant and new edge on the same bit i: the clear wins over the old request, the new edge sets PEND[i]=1, OVR is not set.
- STOP=1: T12 ignored; GNT/CTROR/GNT_IDX hold; edges still latch into PEND; OVR rule still applies.
- GOJAM=1 (sync, highest priority over all updates): PEND=0, GNT=0, GNT_IDX=0, CTROR=0, OVR=0, burst count=0. REQ levels held through GOJAM do not re-trigger afterwards.
- Reset mid-MCT: everything clears immediately, regardless of T12 phase.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: CTR_BURST_LIMIT_EN.
- Defined:
  - Saturating counter burst (0..BURST_MAX) increments on each qualifying T12 that grants, and resets to 0 on each qualifying T12 that does not grant.
  - When burst==BURST_MAX at a qualifying T12, the grant is suppressed for that MCT (CTROR=0, PEND unchanged) and burst resets to 0.
  - Guarantees one instruction MCT per BURST_MAX+1.
- Undefined: no burst counter; grant on every qualifying T12 with PEND≠0 and INKL=0.

Test Plan:
- Reset, pulse REQ[5] and REQ[2] same cycle, then T12 → cycle after: CTROR=1, GNT_IDX=2, PEND=bit5 only. Next T12 → GNT_IDX=5, PEND=0. Following T12 → CTROR=0, GNT=0.
- PEND[3]=1, second rising edge on REQ[3] before its grant → OVR=1, PEND[3]=1. One T12 → GNT_IDX=3, PEND=0, OVR stays 1 until GOJAM.
- PEND[0] set; T12 with INKL=1 → CTROR=0, PEND unchanged. T12 with INKL=0 → GNT_IDX=0.
- STOP=1 with grant on idx 7; three T12 strobes → GNT_IDX stays 7, new edge on REQ[1] sets PEND[1]. STOP=0, T12 → GNT_IDX=1.
- REQ[4] held high, GOJAM pulse, then T12 → PEND=0, CTROR=0, no re-trigger. Async SIM_RST low mid-MCT → all outputs 0 within the same cycle.
- (CTR_BURST_LIMIT_EN, BURST_MAX=4) PEND holds 6 requests, 6 consecutive T12 → CTROR sequence 1,1,1,1,0,1.
